pkt_collector_fifo: RTL and testbench

//  Parametrised packet sink for a router's local output port (one per mesh node).

---
 rtl/pkt_collector_fifo_if.sv | 30 +++
 rtl/pkt_collector_fifo.sv | 100 ++++++++++
 tb/tb_pkt_collector_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pkt_collector_fifo_if.sv
// Router-local-port and consumer-read bundle for pkt_collector_fifo.
// The master side is the router/consumer. The slave side is the collector.
interface pkt_collector_fifo_if #(
  parameter int PACKET_W = 26,
  parameter int PKTID_W  = 10,
  parameter int SRCID_W  = 6,
  parameter int DATA_W   = 9,
  parameter int TS_W     = 16
);
  logic [PACKET_W-1:0] PacketIn;
  logic                ReqUpStr;
  logic                GntUpStr;
  logic                UpStrFull;
  logic                rd_en;
  logic                rd_valid;
  logic [PKTID_W-1:0]  rd_pktid;
  logic [SRCID_W-1:0]  rd_srcid;
  logic [DATA_W-1:0]   rd_data;
  logic [TS_W-1:0]     rd_ts;

  modport master (
    output PacketIn, ReqUpStr, rd_en,
    input  GntUpStr, UpStrFull, rd_valid, rd_pktid, rd_srcid, rd_data, rd_ts
  );

  modport slave (
    input  PacketIn, ReqUpStr, rd_en,
    output GntUpStr, UpStrFull, rd_valid, rd_pktid, rd_srcid, rd_data, rd_ts
  );
endinterface

// File: rtl/pkt_collector_fifo.sv
// Packet sink for a router local port. It grants each packet, timestamps it, and
// queues it in a first-word-fall-through FIFO for a PE or logger.
module pkt_collector_fifo #(
  parameter logic [5:0] ROUTER_ID  = 6'b010_001,
  parameter int         PACKET_W   = 26,
  parameter int         PKTID_W    = 10,
  parameter int         SRCID_W    = 6,
  parameter int         DATA_W     = 9,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TS_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pkt_collector_fifo_if.slave  bus,
  output logic [TS_W-1:0]      cycle_counter,
  output logic [15:0]          rx_count,
  output logic [5:0]           my_id
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PKTID_W-1:0] pktid;
    logic [SRCID_W-1:0] srcid;
    logic [DATA_W-1:0]  data;
    logic [TS_W-1:0]    ts;
  } entry_t;

  typedef enum logic {WAIT_REQ, RECEIVE_DATA} state_t;

  state_t           state;
  entry_t           mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic             full, wr, rd;

  // The reserved top bit of the packet bus is intentionally dropped.
  logic unusedRsvd;
  assign unusedRsvd = bus.PacketIn[PACKET_W-1];

  assign my_id         = ROUTER_ID;
  assign full          = (count == FULL_CNT);
  assign wr            = (state == WAIT_REQ) && bus.ReqUpStr && !full;
  assign rd            = bus.rd_en && (count != '0);
  assign head          = mem[rdPtr];
  assign bus.UpStrFull = full;
  assign bus.rd_valid  = (count != '0);
  assign bus.rd_pktid  = head.pktid;
  assign bus.rd_srcid  = head.srcid;
  assign bus.rd_data   = head.data;
  assign bus.rd_ts     = head.ts;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_REQ;
      bus.GntUpStr <= 1'b0;
    end else begin
      case (state)
        WAIT_REQ: if (wr) begin
          bus.GntUpStr <= 1'b1;
          state        <= RECEIVE_DATA;
        end
        default: begin
          bus.GntUpStr <= 1'b0;
          state        <= WAIT_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_counter <= '0;
      rx_count      <= '0;
      wrPtr         <= '0;
      rdPtr         <= '0;
      count         <= '0;
    end else begin
      cycle_counter <= cycle_counter + TS_W'(1);
      if (wr && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
      if (wr) wrPtr <= wrPtr + PTR_W'(1);
      if (rd) rdPtr <= rdPtr + PTR_W'(1);
      case ({wr, rd})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The storage is left unreset. Only entries between rdPtr and wrPtr are ever presented.
  always_ff @(posedge clk) begin
    if (!reset && wr)
      mem[wrPtr] <= '{pktid: bus.PacketIn[PACKET_W-2 -: PKTID_W],
                      srcid: bus.PacketIn[PACKET_W-2-PKTID_W -: SRCID_W],
                      data:  bus.PacketIn[DATA_W-1:0],
                      ts:    cycle_counter};
  end
endmodule

// File: tb/tb_pkt_collector_fifo.sv
// Directed bench for pkt_collector_fifo. Inputs are driven and outputs sampled on
// the falling edge. Expected values are hand-derived.
module tb_pkt_collector_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cycle_counter;
  logic [15:0] rx_count;
  logic [5:0]  my_id;
  int          checks = 0;
  int          errors = 0;

  pkt_collector_fifo_if #(.PACKET_W(26), .PKTID_W(10), .SRCID_W(6), .DATA_W(9), .TS_W(16)) bus ();

  pkt_collector_fifo dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cycle_counter(cycle_counter), .rx_count(rx_count), .my_id(my_id)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mk(input logic [9:0] id, input logic [5:0] src,
                                     input logic [8:0] d, input logic rsv);
    return {rsv, id, src, d};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.ReqUpStr = 1'b0; bus.rd_en = 1'b0; bus.PacketIn = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.GntUpStr !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b want 0", bus.GntUpStr); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.UpStrFull !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", bus.UpStrFull); end
    checks++; if (cycle_counter !== 16'd0) begin errors++; $display("FAIL rst_cc got %0d want 0", cycle_counter); end
    checks++; if (rx_count !== 16'd0) begin errors++; $display("FAIL rst_rx got %0d want 0", rx_count); end
    checks++; if (my_id !== 6'b010_001) begin errors++; $display("FAIL my_id got %b want 010001", my_id); end
    @(negedge clk);
    checks++; if (cycle_counter !== 16'd1) begin errors++; $display("FAIL cc_inc got %0d want 1", cycle_counter); end
  endtask

  task automatic test_single();
    int n = 0;
    do_reset();
    while (cycle_counter !== 16'd3 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL t1_timeout got cc=%0d want 3", cycle_counter); end
    bus.PacketIn = mk(10'd5, 6'b000_010, 9'h1A5, 1'b0); bus.ReqUpStr = 1'b1;
    @(negedge clk);
    bus.ReqUpStr = 1'b0;
    checks++; if (bus.GntUpStr !== 1'b1) begin errors++; $display("FAIL t1_gnt got %b want 1", bus.GntUpStr); end
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", bus.rd_valid); end
    checks++; if (bus.rd_pktid !== 10'd5) begin errors++; $display("FAIL t1_pktid got %0d want 5", bus.rd_pktid); end
    checks++; if (bus.rd_srcid !== 6'd2) begin errors++; $display("FAIL t1_srcid got %0d want 2", bus.rd_srcid); end
    checks++; if (bus.rd_data !== 9'h1A5) begin errors++; $display("FAIL t1_data got %h want 1a5", bus.rd_data); end
    checks++; if (bus.rd_ts !== 16'd3) begin errors++; $display("FAIL t1_ts got %0d want 3", bus.rd_ts); end
    checks++; if (rx_count !== 16'd1) begin errors++; $display("FAIL t1_rx got %0d want 1", rx_count); end
    @(negedge clk);
    checks++; if (bus.GntUpStr !== 1'b0) begin errors++; $display("FAIL t1_gnt_drop got %b want 0", bus.GntUpStr); end
  endtask

  // Holding ReqUpStr fills the FIFO. Accepts happen at edges 0, 2, 4 and 6.
  task automatic test_back_to_back();
    logic [9:0] gntPat;
    logic [9:0] popIds [4];
    popIds[0] = 10'd12; popIds[1] = 10'd14; popIds[2] = 10'd16; popIds[3] = 10'd99;
    gntPat = '0;
    do_reset();
    for (int j = 0; j < 10; j++) begin
      bus.PacketIn = mk(10'(10 + j), 6'(j), 9'(j * 3), j[1]);
      bus.ReqUpStr = 1'b1;
      @(negedge clk);
      gntPat[j] = bus.GntUpStr;
    end
    checks++; if (gntPat !== 10'b00_0101_0101) begin errors++; $display("FAIL b2b_gnt_pattern got %b want 0001010101", gntPat); end
    checks++; if (bus.UpStrFull !== 1'b1) begin errors++; $display("FAIL b2b_full got %b want 1", bus.UpStrFull); end
    checks++; if (rx_count !== 16'd4) begin errors++; $display("FAIL b2b_rx got %0d want 4", rx_count); end
    checks++; if (bus.rd_pktid !== 10'd10) begin errors++; $display("FAIL b2b_head got %0d want 10", bus.rd_pktid); end
    // A single pop while full frees a slot, but the write still waits one more edge.
    bus.PacketIn = mk(10'd99, 6'd7, 9'h055, 1'b1); bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    checks++; if (bus.UpStrFull !== 1'b0) begin errors++; $display("FAIL full_pop_full got %b want 0", bus.UpStrFull); end
    checks++; if (bus.GntUpStr !== 1'b0) begin errors++; $display("FAIL full_pop_gnt got %b want 0", bus.GntUpStr); end
    checks++; if (bus.rd_pktid !== 10'd12) begin errors++; $display("FAIL full_pop_head got %0d want 12", bus.rd_pktid); end
    @(negedge clk);
    bus.ReqUpStr = 1'b0;
    checks++; if (bus.GntUpStr !== 1'b1) begin errors++; $display("FAIL full_regnt got %b want 1", bus.GntUpStr); end
    checks++; if (bus.UpStrFull !== 1'b1) begin errors++; $display("FAIL full_refull got %b want 1", bus.UpStrFull); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pktid !== popIds[k]) begin
        errors++; $display("FAIL drain%0d got v=%b id=%0d want v=1 id=%0d", k, bus.rd_valid, bus.rd_pktid, popIds[k]); end
      bus.rd_en = 1'b1;
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_simul_rw();
    do_reset();
    bus.PacketIn = mk(10'd1, 6'd1, 9'h001, 1'b0); bus.ReqUpStr = 1'b1;
    @(negedge clk);
    bus.PacketIn = mk(10'd2, 6'd2, 9'h002, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.PacketIn = mk(10'd3, 6'd3, 9'h003, 1'b0);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.ReqUpStr = 1'b0;
    checks++; if (bus.GntUpStr !== 1'b1) begin errors++; $display("FAIL rw_gnt got %b want 1", bus.GntUpStr); end
    checks++; if (bus.rd_pktid !== 10'd2 || bus.rd_data !== 9'h002) begin
      errors++; $display("FAIL rw_head got id=%0d d=%h want id=2 d=002", bus.rd_pktid, bus.rd_data); end
    checks++; if (rx_count !== 16'd3) begin errors++; $display("FAIL rw_rx got %0d want 3", rx_count); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pktid !== 10'd3) begin
      errors++; $display("FAIL rw_second got v=%b id=%0d want v=1 id=3", bus.rd_valid, bus.rd_pktid); end
    @(negedge clk);
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rw_empty got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_reset_midxfer();
    do_reset();
    for (int j = 0; j < 5; j++) begin
      bus.PacketIn = mk(10'(40 + j), 6'd1, 9'(j), 1'b0); bus.ReqUpStr = 1'b1;
      @(negedge clk);
    end
    checks++; if (bus.GntUpStr !== 1'b1 || rx_count !== 16'd3) begin
      errors++; $display("FAIL mid_pre got gnt=%b rx=%0d want gnt=1 rx=3", bus.GntUpStr, rx_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.ReqUpStr = 1'b0;
    checks++; if (bus.GntUpStr !== 1'b0) begin errors++; $display("FAIL mid_gnt got %b want 0", bus.GntUpStr); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.UpStrFull !== 1'b0) begin errors++; $display("FAIL mid_full got %b want 0", bus.UpStrFull); end
    checks++; if (rx_count !== 16'd0) begin errors++; $display("FAIL mid_rx got %0d want 0", rx_count); end
    checks++; if (cycle_counter !== 16'd0) begin errors++; $display("FAIL mid_cc got %0d want 0", cycle_counter); end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    while (cycle_counter !== 16'hFFFF && n < 70000) begin @(negedge clk); n++; end
    checks++; if (n >= 70000) begin errors++; $display("FAIL wrap_timeout got cc=%h want ffff", cycle_counter); end
    bus.PacketIn = mk(10'd123, 6'd5, 9'h1FF, 1'b0); bus.ReqUpStr = 1'b1;
    @(negedge clk);
    bus.ReqUpStr = 1'b0;
    checks++; if (cycle_counter !== 16'd0) begin errors++; $display("FAIL wrap_cc got %h want 0000", cycle_counter); end
    checks++; if (bus.GntUpStr !== 1'b1) begin errors++; $display("FAIL wrap_gnt got %b want 1", bus.GntUpStr); end
    checks++; if (bus.rd_ts !== 16'hFFFF || bus.rd_pktid !== 10'd123) begin
      errors++; $display("FAIL wrap_ts got ts=%h id=%0d want ts=ffff id=123", bus.rd_ts, bus.rd_pktid); end
  endtask

  initial begin
    reset = 1'b1; bus.ReqUpStr = 1'b0; bus.rd_en = 1'b0; bus.PacketIn = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_simul_rw();
    test_reset_midxfer();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
